// File: rtl/sp_ctrl.sv
// sp_ctrl: registered host/engine scratchpad write arbiter plus a ready/valid matrix element streamer.
// Define SP_CTRL_ROUND_ROBIN_EN for round-robin arbitration; otherwise the engine has fixed priority.
module sp_ctrl #(
   parameter int  BUS_WIDTH   = 16,
   parameter int  DATA_WIDTH  = 8,
   parameter int  SP_NTARGETS = 2,
   localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
   localparam int N           = MAX_DIM * MAX_DIM,
   localparam int SUB_W       = 2 * $clog2(MAX_DIM),
   localparam int MAT_W       = BUS_WIDTH * N
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 host_wr_req_i,
   input  logic [1:0]           host_wr_target_i,
   input  logic [MAT_W-1:0]     host_wr_data_i,
   output logic                 host_wr_gnt_o,
   input  logic                 eng_wr_req_i,
   input  logic [1:0]           eng_wr_target_i,
   input  logic [MAT_W-1:0]     eng_wr_data_i,
   output logic                 eng_wr_gnt_o,
   output logic                 sp_ena_write_o,
   output logic [1:0]           sp_write_target_o,
   output logic [MAT_W-1:0]     sp_wdata_o,
   input  logic                 rd_start_i,
   input  logic [1:0]           rd_target_i,
   output logic [1:0]           sp_address_o,
   output logic [SUB_W-1:0]     sp_sub_address_o,
   input  logic [BUS_WIDTH-1:0] sp_rdata_i,
   output logic [BUS_WIDTH-1:0] rd_data_o,
   output logic                 rd_valid_o,
   output logic                 rd_last_o,
   input  logic                 rd_ready_i,
   output logic                 rd_busy_o,
   output logic                 rd_done_o,
   output logic                 err_o
);

   typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} rd_state_e;

   rd_state_e        state_q;
   logic [SUB_W-1:0] idx_q;
   logic [1:0]       tgt_q;
   logic             done_q;
   logic             err_q, err_d;
   logic             host_gnt_q, host_gnt_d;
   logic             eng_gnt_q, eng_gnt_d;
   logic             ena_q, wr_ok_d;
   logic [1:0]       wtgt_q, win_tgt_d;
   logic [MAT_W-1:0] wdata_q, win_data_d;
   logic             host_elig_d, eng_elig_d;
   logic             stream_s, last_s;
`ifdef SP_CTRL_ROUND_ROBIN_EN
   logic             rr_eng_q;
`endif

   function automatic logic target_ok(input logic [1:0] tgt);
      return 32'(tgt) < 32'(SP_NTARGETS);
   endfunction

   assign stream_s = (state_q == STREAM);
   assign last_s   = stream_s && (idx_q == SUB_W'(N - 1));

   // Eligibility, winner selection and error detection for the coming edge.
   always_comb begin
      host_elig_d = host_wr_req_i && !host_gnt_q && !(stream_s && (host_wr_target_i == tgt_q));
      eng_elig_d  = eng_wr_req_i && !eng_gnt_q && !(stream_s && (eng_wr_target_i == tgt_q));
`ifdef SP_CTRL_ROUND_ROBIN_EN
      if (host_elig_d && eng_elig_d) begin
         host_gnt_d = !rr_eng_q;
         eng_gnt_d  = rr_eng_q;
      end else begin
         host_gnt_d = host_elig_d;
         eng_gnt_d  = eng_elig_d;
      end
`else
      eng_gnt_d  = eng_elig_d;
      host_gnt_d = host_elig_d && !eng_elig_d;
`endif
      if (eng_gnt_d) begin
         win_tgt_d  = eng_wr_target_i;
         win_data_d = eng_wr_data_i;
      end else begin
         win_tgt_d  = host_wr_target_i;
         win_data_d = host_wr_data_i;
      end
      wr_ok_d = (host_gnt_d || eng_gnt_d) && target_ok(win_tgt_d);
      err_d   = ((host_gnt_d || eng_gnt_d) && !target_ok(win_tgt_d))
             || (!stream_s && rd_start_i && !target_ok(rd_target_i));
   end

   // Registered grant, write port and error pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         host_gnt_q <= 1'b0;
         eng_gnt_q  <= 1'b0;
         ena_q      <= 1'b0;
         err_q      <= 1'b0;
         wtgt_q     <= 2'd0;
         wdata_q    <= '0;
`ifdef SP_CTRL_ROUND_ROBIN_EN
         rr_eng_q   <= 1'b0;
`endif
      end else begin
         host_gnt_q <= host_gnt_d;
         eng_gnt_q  <= eng_gnt_d;
         ena_q      <= wr_ok_d;
         err_q      <= err_d;
         if (wr_ok_d) begin
            wtgt_q  <= win_tgt_d;
            wdata_q <= win_data_d;
         end
`ifdef SP_CTRL_ROUND_ROBIN_EN
         if (host_gnt_d) begin
            rr_eng_q <= 1'b1;
         end else if (eng_gnt_d) begin
            rr_eng_q <= 1'b0;
         end
`endif
      end
   end

   // Read streamer FSM; the index wraps to zero on the last handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= '0;
         tgt_q   <= 2'd0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rd_start_i && target_ok(rd_target_i)) begin
                  state_q <= STREAM;
                  tgt_q   <= rd_target_i;
                  idx_q   <= '0;
               end
            end
            STREAM: begin
               if (rd_ready_i) begin
                  idx_q <= idx_q + SUB_W'(1);
                  if (last_s) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign host_wr_gnt_o     = host_gnt_q;
   assign eng_wr_gnt_o      = eng_gnt_q;
   assign sp_ena_write_o    = ena_q;
   assign sp_write_target_o = wtgt_q;
   assign sp_wdata_o        = wdata_q;
   assign sp_address_o      = tgt_q;
   assign sp_sub_address_o  = idx_q;
   assign rd_data_o         = stream_s ? sp_rdata_i : '0;
   assign rd_valid_o        = stream_s;
   assign rd_last_o         = last_s;
   assign rd_busy_o         = stream_s;
   assign rd_done_o         = done_q;
   assign err_o             = err_q;

endmodule
